// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm clock controller: mode/alarm-state
// encodings, time constants and the wrap-around field increment.
package alarm_pkg;

  typedef enum logic [2:0] {
    MODE_RUN    = 3'd0,
    MODE_SET_TH = 3'd1,
    MODE_SET_TM = 3'd2,
    MODE_SET_AH = 3'd3,
    MODE_SET_AM = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    AL_IDLE    = 2'd0,
    AL_RINGING = 2'd1,
    AL_SNOOZE  = 2'd2
  } alarm_st_e;

  localparam logic [5:0] HOURS_PER_DAY = 6'd24;
  localparam logic [5:0] MIN_PER_HOUR  = 6'd60;

  // Increment v modulo lim; hours are passed zero-extended to 6 bits.
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] lim);
    return (v >= lim - 6'd1) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/ring_sequencer.sv
// Alarm ring/snooze/timeout FSM with registered match edge detection and
// the snooze target computed at the moment snooze is pressed.
module ring_sequencer
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_i,
  input  logic [4:0] cur_h_i,
  input  logic [5:0] cur_m_i,
  input  logic [4:0] alarm_h_i,
  input  logic [5:0] alarm_m_i,
  input  logic       arm_i,
  input  logic       snooze_i,
  input  logic       trig_en_i,
  input  logic       force_idle_i,
  output logic       ring_o
);
  localparam int RW = $clog2(RING_TIMEOUT_S + 1);

  alarm_st_e     st_q, st_d;
  logic          match_q, match_prev_q, snz_q, snz_prev_q, ring_q;
  logic [4:0]    tgt_h_q, tgt_h_d;
  logic [5:0]    tgt_m_q, tgt_m_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic          match_rise, snz_rise;
  logic [6:0]    m_sum;

  assign match_rise = match_q & ~match_prev_q;
  assign snz_rise   = snz_q & ~snz_prev_q;
  assign m_sum      = {1'b0, cur_m_i} + 7'(SNOOZE_MIN);

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    tgt_h_d = tgt_h_q;
    tgt_m_d = tgt_m_q;
    // Disarm and entry into alarm editing override every other transition.
    if (!arm_i || force_idle_i) begin
      st_d = AL_IDLE;
    end else begin
      case (st_q)
        AL_IDLE: if (match_rise && trig_en_i) begin
          st_d  = AL_RINGING;
          cnt_d = '0;
        end
        AL_RINGING: begin
          if (snooze_i) begin
            st_d = AL_SNOOZE;
            if (m_sum >= 7'(MIN_PER_HOUR)) begin
              tgt_m_d = 6'(m_sum - 7'(MIN_PER_HOUR));
              tgt_h_d = 5'(wrap_inc({1'b0, cur_h_i}, HOURS_PER_DAY));
            end else begin
              tgt_m_d = m_sum[5:0];
              tgt_h_d = cur_h_i;
            end
          end else if (tick_i) begin
            if (cnt_q == RW'(RING_TIMEOUT_S - 1)) st_d = AL_IDLE;
            else                                   cnt_d = cnt_q + 1'b1;
          end
        end
        AL_SNOOZE: if (snz_rise) begin
          st_d  = AL_RINGING;
          cnt_d = '0;
        end
        default: st_d = AL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q         <= AL_IDLE;
      cnt_q        <= '0;
      tgt_h_q      <= '0;
      tgt_m_q      <= '0;
      match_q      <= 1'b0;
      match_prev_q <= 1'b0;
      snz_q        <= 1'b0;
      snz_prev_q   <= 1'b0;
      ring_q       <= 1'b0;
    end else begin
      st_q         <= st_d;
      cnt_q        <= cnt_d;
      tgt_h_q      <= tgt_h_d;
      tgt_m_q      <= tgt_m_d;
      match_q      <= arm_i && (cur_h_i == alarm_h_i) && (cur_m_i == alarm_m_i);
      match_prev_q <= match_q;
      snz_q        <= arm_i && (cur_h_i == tgt_h_q) && (cur_m_i == tgt_m_q);
      snz_prev_q   <= snz_q;
      ring_q       <= (st_d == AL_RINGING);
    end
  end

  assign ring_o = ring_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Front-panel sequencer for the alarm clock: mode FSM, time/alarm edit
// registers, digit blink and edit timeout; ringing lives in ring_sequencer.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  parameter int SET_TIMEOUT_S  = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz_i,
  input  logic [4:0] cur_h_i,
  input  logic [5:0] cur_m_i,
  input  logic       btn_mode_i,
  input  logic       btn_inc_i,
  input  logic       btn_snooze_i,
  input  logic       arm_sw_i,
  output logic       ld_time_o,
  output logic [4:0] ld_h_o,
  output logic [5:0] ld_m_o,
  output logic [4:0] alarm_h_o,
  output logic [5:0] alarm_m_o,
  output logic [2:0] mode_o,
  output logic       blink_o,
  output logic       ring_o
);
  localparam int SW = $clog2(SET_TIMEOUT_S + 1);

  mode_e         mode_q, mode_d;
  logic [4:0]    ld_h_q, ld_h_d, al_h_q, al_h_d;
  logic [5:0]    ld_m_q, ld_m_d, al_m_q, al_m_d;
  logic [SW-1:0] set_cnt_q, set_cnt_d;
  logic          ld_time_q, ld_time_d, blink_q, blink_d;
  logic          enter_ah, trig_en;

  assign enter_ah = btn_mode_i && (mode_q == MODE_SET_TM);
  assign trig_en  = (mode_q == MODE_RUN) || (mode_q == MODE_SET_TH) || (mode_q == MODE_SET_TM);

  always_comb begin
    mode_d    = mode_q;
    ld_h_d    = ld_h_q;
    ld_m_d    = ld_m_q;
    al_h_d    = al_h_q;
    al_m_d    = al_m_q;
    set_cnt_d = set_cnt_q;
    ld_time_d = 1'b0;
    if (btn_mode_i) begin
      set_cnt_d = '0;
      case (mode_q)
        MODE_RUN: begin
          mode_d = MODE_SET_TH;
          ld_h_d = cur_h_i;
          ld_m_d = cur_m_i;
        end
        MODE_SET_TH: mode_d = MODE_SET_TM;
        MODE_SET_TM: begin
          mode_d    = MODE_SET_AH;
          ld_time_d = 1'b1;
        end
        MODE_SET_AH: mode_d = MODE_SET_AM;
        default:     mode_d = MODE_RUN;
      endcase
    end else if (mode_q != MODE_RUN) begin
      if (btn_inc_i) begin
        set_cnt_d = '0;
        case (mode_q)
          MODE_SET_TH: ld_h_d = 5'(wrap_inc({1'b0, ld_h_q}, HOURS_PER_DAY));
          MODE_SET_TM: ld_m_d = wrap_inc(ld_m_q, MIN_PER_HOUR);
          MODE_SET_AH: al_h_d = 5'(wrap_inc({1'b0, al_h_q}, HOURS_PER_DAY));
          default:     al_m_d = wrap_inc(al_m_q, MIN_PER_HOUR);
        endcase
      end else if (tick_1hz_i) begin
        // Abandon the edit silently: no load strobe, alarm edits stay.
        if (set_cnt_q == SW'(SET_TIMEOUT_S - 1)) begin
          mode_d    = MODE_RUN;
          set_cnt_d = '0;
        end else begin
          set_cnt_d = set_cnt_q + 1'b1;
        end
      end
    end
    blink_d = (mode_d == MODE_RUN) ? 1'b0 : (blink_q ^ tick_1hz_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= MODE_RUN;
      ld_h_q    <= '0;
      ld_m_q    <= '0;
      al_h_q    <= '0;
      al_m_q    <= '0;
      set_cnt_q <= '0;
      ld_time_q <= 1'b0;
      blink_q   <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      ld_h_q    <= ld_h_d;
      ld_m_q    <= ld_m_d;
      al_h_q    <= al_h_d;
      al_m_q    <= al_m_d;
      set_cnt_q <= set_cnt_d;
      ld_time_q <= ld_time_d;
      blink_q   <= blink_d;
    end
  end

  ring_sequencer #(
    .SNOOZE_MIN    (SNOOZE_MIN),
    .RING_TIMEOUT_S(RING_TIMEOUT_S)
  ) u_ring (
    .clk         (clk),
    .rst         (rst),
    .tick_i      (tick_1hz_i),
    .cur_h_i     (cur_h_i),
    .cur_m_i     (cur_m_i),
    .alarm_h_i   (al_h_q),
    .alarm_m_i   (al_m_q),
    .arm_i       (arm_sw_i),
    .snooze_i    (btn_snooze_i),
    .trig_en_i   (trig_en),
    .force_idle_i(enter_ah),
    .ring_o      (ring_o)
  );

  assign ld_time_o = ld_time_q;
  assign ld_h_o    = ld_h_q;
  assign ld_m_o    = ld_m_q;
  assign alarm_h_o = al_h_q;
  assign alarm_m_o = al_m_q;
  assign mode_o    = mode_q;
  assign blink_o   = blink_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: ld_time loads are checked against a scoreboard of
// expected (hour, minute) pairs; other behaviour via direct checks.
module tb_alarm_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [4:0] cur_h;
  logic [5:0] cur_m;
  logic       btn_mode, btn_inc, btn_snooze, arm_sw;
  logic       ld_time;
  logic [4:0] ld_h, alarm_h;
  logic [5:0] ld_m, alarm_m;
  logic [2:0] mode;
  logic       blink, ring;

  typedef struct { int h; int m; } ld_exp_t;
  ld_exp_t sb_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alarm_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .tick_1hz_i  (tick),
    .cur_h_i     (cur_h),
    .cur_m_i     (cur_m),
    .btn_mode_i  (btn_mode),
    .btn_inc_i   (btn_inc),
    .btn_snooze_i(btn_snooze),
    .arm_sw_i    (arm_sw),
    .ld_time_o   (ld_time),
    .ld_h_o      (ld_h),
    .ld_m_o      (ld_m),
    .alarm_h_o   (alarm_h),
    .alarm_m_o   (alarm_m),
    .mode_o      (mode),
    .blink_o     (blink),
    .ring_o      (ring)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every ld_time strobe must match a queued load.
  always @(negedge clk) begin
    if (!rst && ld_time === 1'b1) begin
      if (sb_q.size() == 0) chk("ld_time_unexpected", 1, 0);
      else begin
        ld_exp_t e;
        e = sb_q.pop_front();
        chk("sb_ld_h", int'(ld_h), e.h);
        chk("sb_ld_m", int'(ld_m), e.m);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic p_mode();   btn_mode = 1'b1;   cyc(1); btn_mode = 1'b0;   endtask
  task automatic p_inc(input int n);
    repeat (n) begin btn_inc = 1'b1; cyc(1); btn_inc = 1'b0; end
  endtask
  task automatic p_tick(input int n);
    repeat (n) begin tick = 1'b1; cyc(1); tick = 1'b0; end
  endtask
  task automatic set_cur(input int h, input int m);
    cur_h = 5'(h); cur_m = 6'(m);
  endtask

  initial begin
    rst = 1'b1; tick = 0; btn_mode = 0; btn_inc = 0; btn_snooze = 0; arm_sw = 0;
    set_cur(10, 15);
    cyc(2);
    chk("rst_mode", int'(mode), 0);
    chk("rst_ring", int'(ring), 0);
    chk("rst_ld_time", int'(ld_time), 0);
    chk("rst_blink", int'(blink), 0);
    chk("rst_alarm_h", int'(alarm_h), 0);
    chk("rst_ld_h", int'(ld_h), 0);
    rst = 1'b0;
    cyc(1);

    // Set time 10:15 -> 13:05
    p_mode();
    chk("set_mode_th", int'(mode), 1);
    chk("copy_ld_h", int'(ld_h), 10);
    chk("copy_ld_m", int'(ld_m), 15);
    p_inc(3);
    chk("inc_ld_h", int'(ld_h), 13);
    p_mode();
    p_inc(50);
    chk("inc_ld_m_wrap", int'(ld_m), 5);
    chk("no_hour_carry", int'(ld_h), 13);
    sb_q.push_back('{13, 5});
    p_mode();
    chk("ld_time_pulse", int'(ld_time), 1);
    chk("mode_ah", int'(mode), 3);
    cyc(1);
    chk("ld_time_one_cycle", int'(ld_time), 0);

    // Blink in a set mode
    p_tick(1);
    chk("blink_1", int'(blink), 1);
    p_tick(1);
    chk("blink_0", int'(blink), 0);

    // Alarm field wraps, finishing at 07:00
    p_inc(23);
    chk("al_h_23", int'(alarm_h), 23);
    p_inc(1);
    chk("al_h_wrap", int'(alarm_h), 0);
    p_inc(7);
    p_mode();
    p_inc(59);
    chk("al_m_59", int'(alarm_m), 59);
    p_inc(1);
    chk("al_m_wrap", int'(alarm_m), 0);
    chk("al_h_kept", int'(alarm_h), 7);
    btn_inc = 1'b1; tick = 1'b1; cyc(1); btn_inc = 1'b0; tick = 1'b0;
    chk("blink_tick_in_set", int'(blink), 1);
    p_mode();
    chk("mode_run", int'(mode), 0);
    chk("blink_run", int'(blink), 0);
    p_inc(2);
    chk("inc_ignored_run", int'(alarm_m), 1);

    // Alarm is 07:01 after the extra inc in SET_AM; trigger on it
    arm_sw = 1'b1;
    set_cur(7, 0); cyc(3);
    set_cur(7, 1);
    cyc(1);
    chk("ring_lat1", int'(ring), 0);
    cyc(1);
    chk("ring_lat2", int'(ring), 1);
    p_tick(59);
    chk("ring_59", int'(ring), 1);
    p_tick(1);
    chk("ring_timeout", int'(ring), 0);
    cyc(5);
    chk("no_refire", int'(ring), 0);

    // Program alarm 23:58, then snooze across midnight
    p_mode(); p_mode();
    sb_q.push_back('{7, 1});
    p_mode();
    p_inc(16);
    p_mode();
    p_inc(57);
    p_mode();
    chk("alarm_2358_h", int'(alarm_h), 23);
    chk("alarm_2358_m", int'(alarm_m), 58);
    set_cur(23, 57); cyc(3);
    set_cur(23, 58); cyc(2);
    chk("ring_2358", int'(ring), 1);
    btn_snooze = 1'b1; cyc(1); btn_snooze = 1'b0;
    chk("snooze_off", int'(ring), 0);
    set_cur(0, 2); cyc(3);
    chk("snooze_wait", int'(ring), 0);
    set_cur(0, 3); cyc(1);
    chk("snooze_lat1", int'(ring), 0);
    cyc(1);
    chk("snooze_ring", int'(ring), 1);

    // Disarm while ringing; then abandon an edit by timeout
    arm_sw = 1'b0; cyc(1);
    chk("disarm_off", int'(ring), 0);
    p_mode(); p_mode();
    p_tick(29);
    chk("set_to_29", int'(mode), 2);
    p_tick(1);
    chk("set_timeout_run", int'(mode), 0);

    // Mode and inc together: inc dropped
    p_mode();
    chk("sim_ld_h0", int'(ld_h), 0);
    btn_mode = 1'b1; btn_inc = 1'b1; cyc(1); btn_mode = 1'b0; btn_inc = 1'b0;
    chk("sim_mode", int'(mode), 2);
    chk("sim_ld_h", int'(ld_h), 0);
    sb_q.push_back('{0, 3});
    p_mode(); p_mode(); p_mode();
    chk("sim_back_run", int'(mode), 0);

    // Snooze on the final timeout tick wins
    arm_sw = 1'b1;
    set_cur(23, 57); cyc(3);
    set_cur(23, 58); cyc(2);
    chk("ring_again", int'(ring), 1);
    p_tick(59);
    tick = 1'b1; btn_snooze = 1'b1; cyc(1); tick = 1'b0; btn_snooze = 1'b0;
    chk("snz_tick_off", int'(ring), 0);
    set_cur(0, 3); cyc(2);
    chk("snz_tick_ring", int'(ring), 1);

    // Async reset mid-ring
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ring", int'(ring), 0);
    chk("async_rst_alarm", int'(alarm_m), 0);
    cyc(1);
    rst = 1'b0;
    cyc(3);
    chk("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    chk("global_timeout", 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
